// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the lfsr_rng random-number source:
//   rng_state_t      draw FSM states (IDLE, SEARCH, HOLD)
//   TAPS_W8/12/16    maximal-length Fibonacci feedback masks for common widths
//   lfsr_next()      one Fibonacci step for widths up to 32 bits; used by the
//                    core and by any reference model
// ----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2
    } rng_state_t;

    // Bit i set means state[i] feeds the XOR.
    localparam logic [7:0]  TAPS_W8  = 8'hB8;    // x^8+x^6+x^5+x^4+1
    localparam logic [11:0] TAPS_W12 = 12'hE08;  // x^12+x^11+x^10+x^4+1
    localparam logic [15:0] TAPS_W16 = 16'hD008; // x^16+x^15+x^13+x^4+1

    // Shift left by one and insert the XOR of the tapped bits at bit 0.
    // Bits above 'width' are ignored on input and cleared on output.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input int unsigned width);
        logic [31:0] mask;
        logic        fb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb   = ^(state & taps & mask);
        return ((state << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// ----------------------------------------------------------------------------
// lfsr_core
// LFSR state register with seed load, single-step advance and all-zero
// recovery.
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous active-low reset (state <= SEED)
//   load        in   1      load load_val (highest priority)
//   load_val    in   WIDTH  value to load; zero is replaced by SEED
//   advance     in   1      shift one step this edge
//   state       out  WIDTH  current LFSR state
//   next_state  out  WIDTH  value the state takes when it advances
// ----------------------------------------------------------------------------
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int              WIDTH = 12,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_W12),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(12'hB76)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             advance,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    // An all-zero LFSR would lock up, so its successor is SEED instead.
    always_comb begin
        next_state = WIDTH'(lfsr_next(32'(state), 32'(TAPS), WIDTH));
        if (state == '0) begin
            next_state = SEED;
        end
    end

    // A zero state is replaced on the very next edge even without advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_val != '0) ? load_val : SEED;
        end else if (advance || state == '0) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// ----------------------------------------------------------------------------
// lfsr_rng
// Fibonacci LFSR random source with seed load, free-run stepping and a
// range-qualified req/valid/ack draw returning a value in [MIN_VAL, MAX_VAL].
// Optional feature macro: LFSR_RNG_STEPCNT_EN adds output step_cnt[31:0],
// counting every LFSR shift; cleared by reset and by load.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   load       in   1      load load_val into the LFSR, abort any draw
//   load_val   in   WIDTH  seed value; zero is replaced by SEED
//   step       in   1      advance the LFSR one step (IDLE only)
//   req        in   1      start a draw (IDLE only; wins over step)
//   ack        in   1      consumer takes rand_out while valid
//   state_out  out  WIDTH  raw LFSR state
//   rand_out   out  WIDTH  qualified draw, stable while valid
//   valid      out  1      rand_out holds an in-range value
//   busy       out  1      draw in progress (SEARCH)
//   timeout    out  1      one-cycle pulse when MAX_TRIES steps all missed
//   step_cnt   out  32     shift counter (only with LFSR_RNG_STEPCNT_EN)
// ----------------------------------------------------------------------------
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_W12),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(12'hB76),
    parameter int unsigned      MIN_VAL   = 500,
    parameter int unsigned      MAX_VAL   = 4095,
    parameter int unsigned      MAX_TRIES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic             req,
    input  logic             ack,
    output logic [WIDTH-1:0] state_out,
    output logic [WIDTH-1:0] rand_out,
    output logic             valid,
    output logic             busy,
    output logic             timeout
`ifdef LFSR_RNG_STEPCNT_EN
    ,
    output logic [31:0]      step_cnt
`endif
);

    localparam int               TRY_W    = $clog2(MAX_TRIES) + 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] SPAN     = WIDTH'(MAX_VAL - MIN_VAL);

    rng_state_t       fsm;
    logic [TRY_W-1:0] tries;
    logic [WIDTH-1:0] next_state;
    logic             advance;
    logic             in_range;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .advance    (advance),
        .state      (state_out),
        .next_state (next_state)
    );

    // The LFSR moves on a plain step in IDLE (unless req claims the cycle)
    // and on every SEARCH cycle; it is frozen in HOLD and whenever load wins.
    always_comb begin
        advance = 1'b0;
        if (!load) begin
            case (fsm)
                IDLE:    advance = step && !req;
                SEARCH:  advance = 1'b1;
                default: advance = 1'b0;
            endcase
        end
    end

    // Single unsigned window test: values below MIN_VAL wrap to large
    // offsets and fall outside the span.
    assign in_range = (next_state - MIN_W) <= SPAN;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            tries    <= '0;
            rand_out <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (load) begin
                fsm   <= IDLE;
                tries <= '0;
                valid <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (fsm)
                    IDLE: begin
                        if (req) begin
                            fsm   <= SEARCH;
                            tries <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    SEARCH: begin
                        if (in_range) begin
                            rand_out <= next_state;
                            valid    <= 1'b1;
                            busy     <= 1'b0;
                            fsm      <= HOLD;
                        end else if (tries == LAST_TRY) begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            fsm     <= IDLE;
                        end else begin
                            tries <= tries + TRY_W'(1);
                        end
                    end
                    HOLD: begin
                        if (ack) begin
                            valid <= 1'b0;
                            fsm   <= IDLE;
                        end
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

`ifdef LFSR_RNG_STEPCNT_EN
    // Zero recovery reloads SEED in place of a shift and is counted as one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (load) begin
            step_cnt <= '0;
        end else if (advance || state_out == '0) begin
            step_cnt <= step_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// ----------------------------------------------------------------------------
// tb_lfsr_rng
// Four lfsr_rng instances with different draw windows share one stimulus
// stream; a per-instance LFSR model predicts each draw into a scoreboard.
//   inst 0: window [0, 0xFFF]      inst 1: window [0xD00, 0xFFF]
//   inst 2: window [1, 1], 4 tries inst 3: default window [500, 4095]
// ----------------------------------------------------------------------------
module tb_lfsr_rng;
    import lfsr_pkg::*;

    localparam logic [11:0] SEED = 12'hB76;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [11:0] load_val;
    logic        step;
    logic        req;
    logic        ack;

    logic [11:0] state_o   [4];
    logic [11:0] rand_o    [4];
    logic        valid_o   [4];
    logic        busy_o    [4];
    logic        timeout_o [4];
`ifdef LFSR_RNG_STEPCNT_EN
    logic [31:0] cnt_o     [4];
`endif

    int unsigned min_v   [4] = '{0, 32'hD00, 1, 500};
    int unsigned max_v   [4] = '{32'hFFF, 32'hFFF, 1, 4095};
    int unsigned tries_v [4] = '{64, 64, 4, 64};

    typedef struct {
        int          inst;
        logic        is_to;
        logic [11:0] value;
        int          lat;
    } exp_t;

    exp_t        sb [$];
    logic [11:0] mstate  [4];
    logic [11:0] exp_val [4];
    logic        exp_to  [4];
    int          got_lat [4];
    logic        got_to  [4];
    logic [11:0] got_val [4];
    logic        done    [4];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lfsr_rng #(.MIN_VAL(0), .MAX_VAL(4095), .MAX_TRIES(64)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .step(step), .req(req), .ack(ack), .state_out(state_o[0]),
        .rand_out(rand_o[0]), .valid(valid_o[0]), .busy(busy_o[0]),
        .timeout(timeout_o[0])
`ifdef LFSR_RNG_STEPCNT_EN
        , .step_cnt(cnt_o[0])
`endif
    );

    lfsr_rng #(.MIN_VAL(32'hD00), .MAX_VAL(4095), .MAX_TRIES(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .step(step), .req(req), .ack(ack), .state_out(state_o[1]),
        .rand_out(rand_o[1]), .valid(valid_o[1]), .busy(busy_o[1]),
        .timeout(timeout_o[1])
`ifdef LFSR_RNG_STEPCNT_EN
        , .step_cnt(cnt_o[1])
`endif
    );

    lfsr_rng #(.MIN_VAL(1), .MAX_VAL(1), .MAX_TRIES(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .step(step), .req(req), .ack(ack), .state_out(state_o[2]),
        .rand_out(rand_o[2]), .valid(valid_o[2]), .busy(busy_o[2]),
        .timeout(timeout_o[2])
`ifdef LFSR_RNG_STEPCNT_EN
        , .step_cnt(cnt_o[2])
`endif
    );

    lfsr_rng dut3 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .step(step), .req(req), .ack(ack), .state_out(state_o[3]),
        .rand_out(rand_o[3]), .valid(valid_o[3]), .busy(busy_o[3]),
        .timeout(timeout_o[3])
`ifdef LFSR_RNG_STEPCNT_EN
        , .step_cnt(cnt_o[3])
`endif
    );

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] expected);
        vectors++;
        if (got !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, got, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] modelStep(input logic [11:0] s);
        if (s == 12'h000) return SEED;
        return 12'(lfsr_next(32'(s), 32'(TAPS_W12), 12));
    endfunction

    function automatic logic allDone();
        return done[0] && done[1] && done[2] && done[3];
    endfunction

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) mstate[k] = SEED;
    endtask

    task automatic checkIdleAfterReset(input string tag);
        for (int k = 0; k < 4; k++) begin
            checkOutput({tag, "_state"},   32'(state_o[k]), 32'(SEED));
            checkOutput({tag, "_rand"},    32'(rand_o[k]),  32'd0);
            checkOutput({tag, "_valid"},   32'(valid_o[k]), 32'd0);
            checkOutput({tag, "_busy"},    32'(busy_o[k]),  32'd0);
            checkOutput({tag, "_timeout"}, 32'(timeout_o[k]), 32'd0);
        end
    endtask

    // Free-run steps; every instance must track its model.
    task automatic applyStimulus(input int n);
        step = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            for (int k = 0; k < 4; k++) mstate[k] = modelStep(mstate[k]);
        end
        step = 1'b0;
        for (int k = 0; k < 4; k++)
            checkOutput("free_step", 32'(state_o[k]), 32'(mstate[k]));
    endtask

    // Predict one draw per instance from its model state.
    task automatic modelDraw(input int k);
        logic [11:0] s;
        exp_t        e;
        s       = mstate[k];
        e.inst  = k;
        e.is_to = 1'b0;
        e.value = 12'h000;
        e.lat   = 0;
        for (int n = 1; n <= int'(tries_v[k]); n++) begin
            s = modelStep(s);
            if (32'(s) >= min_v[k] && 32'(s) <= max_v[k]) begin
                e.value = s;
                e.lat   = n;
                break;
            end
        end
        if (e.lat == 0) begin
            e.is_to = 1'b1;
            e.lat   = int'(tries_v[k]);
        end
        mstate[k] = s;
        sb.push_back(e);
    endtask

    // Pulse req (optionally together with step), wait for every instance to
    // report valid or timeout, then score the results.
    task automatic applyDraw(input logic with_step);
        int   n;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            modelDraw(k);
            done[k]    = 1'b0;
            got_lat[k] = -1;
            got_to[k]  = 1'b0;
            got_val[k] = 12'h000;
        end
        req  = 1'b1;
        step = with_step;
        tick();
        req  = 1'b0;
        step = 1'b0;
        for (int k = 0; k < 4; k++)
            checkOutput("busy_on_accept", 32'(busy_o[k]), 32'd1);
        n = 0;
        while (!allDone() && n < 100) begin
            tick();
            n++;
            for (int k = 0; k < 4; k++) begin
                if (!done[k] && (valid_o[k] || timeout_o[k])) begin
                    done[k]    = 1'b1;
                    got_lat[k] = n;
                    got_to[k]  = timeout_o[k];
                    got_val[k] = rand_o[k];
                    checkOutput("busy_off_done", 32'(busy_o[k]), 32'd0);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                exp_val[e.inst] = e.value;
                exp_to[e.inst]  = e.is_to;
                checkOutput("draw_kind",    32'(got_to[e.inst]),  32'(e.is_to));
                checkOutput("draw_latency", 32'(got_lat[e.inst]), 32'(e.lat));
                if (!e.is_to)
                    checkOutput("draw_value", 32'(got_val[e.inst]), 32'(e.value));
            end
        end
    endtask

    // Hold the result with ack low while stepping (ignored in HOLD, honoured
    // by instances that timed out), then acknowledge.
    task automatic finishDraw();
        step = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (exp_to[k]) begin
                    mstate[k] = modelStep(mstate[k]);
                    checkOutput("idle_step",  32'(state_o[k]), 32'(mstate[k]));
                    checkOutput("idle_valid", 32'(valid_o[k]), 32'd0);
                end else begin
                    checkOutput("hold_valid", 32'(valid_o[k]), 32'd1);
                    checkOutput("hold_rand",  32'(rand_o[k]),  32'(exp_val[k]));
                    checkOutput("hold_state", 32'(state_o[k]), 32'(exp_val[k]));
                end
                checkOutput("timeout_pulse", 32'(timeout_o[k]), 32'd0);
            end
        end
        step = 1'b0;
        ack  = 1'b1;
        tick();
        ack  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("ack_valid", 32'(valid_o[k]), 32'd0);
            checkOutput("ack_busy",  32'(busy_o[k]),  32'd0);
        end
    endtask

    initial begin
        int first_ret;
        int zero_seen;

        rst_n    = 1'b0;
        load     = 1'b0;
        load_val = 12'h000;
        step     = 1'b0;
        req      = 1'b0;
        ack      = 1'b0;

        // Reset values, then two plain steps from SEED.
        doReset();
        checkIdleAfterReset("reset");
        step = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) checkOutput("step1", 32'(state_o[k]), 32'h6EC);
        tick();
        for (int k = 0; k < 4; k++) checkOutput("step2", 32'(state_o[k]), 32'hDD9);
        step = 1'b0;

        // First draw from SEED against the known sequence.
        doReset();
        applyDraw(1'b0);
        checkOutput("wide_rand",     32'(got_val[0]), 32'h6EC);
        checkOutput("wide_latency",  32'(got_lat[0]), 32'd1);
        checkOutput("reject_rand",   32'(got_val[1]), 32'hDD9);
        checkOutput("reject_lat",    32'(got_lat[1]), 32'd2);
        checkOutput("narrow_to",     32'(got_to[2]),  32'd1);
        checkOutput("narrow_to_lat", 32'(got_lat[2]), 32'd4);
        checkOutput("narrow_valid",  32'(valid_o[2]), 32'd0);
        finishDraw();

        // Further draws from scattered states; the middle one has req and
        // step together.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(int'($urandom_range(1, 6)));
            applyDraw(i == 1);
            finishDraw();
        end

        // Load of zero substitutes SEED; a real value loads directly.
        load     = 1'b1;
        load_val = 12'h000;
        tick();
        for (int k = 0; k < 4; k++) checkOutput("load_zero", 32'(state_o[k]), 32'(SEED));
`ifdef LFSR_RNG_STEPCNT_EN
        for (int k = 0; k < 4; k++) checkOutput("load_cnt_clr", cnt_o[k], 32'd0);
`endif
        load_val = 12'h5A5;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) checkOutput("load_val", 32'(state_o[k]), 32'h5A5);

        // Load during SEARCH aborts every draw without valid or timeout.
        req = 1'b1;
        tick();
        req      = 1'b0;
        load     = 1'b1;
        load_val = 12'h3C3;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("abort_busy",  32'(busy_o[k]),  32'd0);
            checkOutput("abort_valid", 32'(valid_o[k]), 32'd0);
            checkOutput("abort_state", 32'(state_o[k]), 32'h3C3);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                checkOutput("abort_no_to",    32'(timeout_o[k]), 32'd0);
                checkOutput("abort_no_valid", 32'(valid_o[k]),   32'd0);
                checkOutput("abort_frozen",   32'(state_o[k]),   32'h3C3);
            end
        end
        for (int k = 0; k < 4; k++) mstate[k] = 12'h3C3;

        // Load during HOLD drops valid.
        applyDraw(1'b0);
        load     = 1'b1;
        load_val = 12'h111;
        tick();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("hold_load_valid", 32'(valid_o[k]), 32'd0);
            checkOutput("hold_load_state", 32'(state_o[k]), 32'h111);
        end

        // Reset in the middle of a draw.
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checkIdleAfterReset("mid_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) mstate[k] = SEED;

        // Full period from SEED: first return to SEED after 4095 steps,
        // never passing through zero.
        first_ret = -1;
        zero_seen = 0;
        step = 1'b1;
        for (int i = 1; i <= 4095; i++) begin
            tick();
            if (state_o[3] == 12'h000) zero_seen++;
            if (state_o[3] == SEED && first_ret < 0) first_ret = i;
        end
        step = 1'b0;
        checkOutput("period", 32'(first_ret), 32'd4095);
        checkOutput("zero_seen", 32'(zero_seen), 32'd0);
        for (int k = 0; k < 4; k++) checkOutput("period_state", 32'(state_o[k]), 32'(SEED));
`ifdef LFSR_RNG_STEPCNT_EN
        for (int k = 0; k < 4; k++) checkOutput("step_cnt", cnt_o[k], 32'd4095);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
